// File: rtl/mod4591_pkg.sv
// Shared constants, stage bundles and helpers for the mod-4591 reducer.
// Imported by the split, final-correction and arbiter modules.
package mod4591_pkg;

  localparam int unsigned Q      = 4591;
  localparam int unsigned OFFSET = 3 * Q;
  localparam int unsigned Z_W    = 33;
  localparam int unsigned S_W    = 15;
  localparam int unsigned R_W    = 13;
  localparam int unsigned N_W    = 12;
  localparam int unsigned Q1     = Q;
  localparam int unsigned Q2     = 2 * Q;
  localparam int unsigned Q3     = 3 * Q;
  localparam int unsigned Q4     = 4 * Q;

  // Chunk residues at or above SPLIT go out as a negative term, keeping
  // each n <= 3443 so four of them never exceed OFFSET.
  localparam int unsigned SPLIT  = Q - 3443;

  typedef struct packed {
    logic           v;
    logic           tag;
    logic [Z_W-1:0] z;
  } s1_t;

  typedef struct packed {
    logic           v;
    logic           tag;
    logic [R_W-1:0] p0;
    logic [R_W-1:0] p1;
    logic [N_W-1:0] n0;
    logic [N_W-1:0] n1;
    logic [N_W-1:0] n2;
    logic [N_W-1:0] n3;
  } s2_t;

  typedef struct packed {
    logic           v;
    logic           tag;
    logic [S_W-1:0] s;
  } s3_t;

  typedef struct packed {
    logic [R_W-1:0] pos;
    logic [N_W-1:0] neg;
  } term_t;

  function automatic int unsigned pow2_mod(input int unsigned b);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < b; i++) r = (r * 2) % Q;
    return r;
  endfunction

  function automatic logic [R_W-1:0] chunk_res(
    input logic [5:0]  c,
    input int unsigned w
  );
    int unsigned x;
    x = {26'd0, c} * w;
    return R_W'(x % Q);
  endfunction

  function automatic term_t fold(input logic [R_W-1:0] r);
    term_t t;
    t = '0;
    if (32'(r) >= SPLIT) t.neg = N_W'(Q - 32'(r));
    else t.pos = r;
    return t;
  endfunction

endpackage

// File: rtl/mod4591Svec33.sv
// Splits a 33-bit operand into low bits plus four chunk residues,
// each folded into a small positive or negative term.
module mod4591Svec33
  import mod4591_pkg::*;
(
  input  logic [Z_W-1:0] z,
  output logic [R_W-1:0] p0,
  output logic [R_W-1:0] p1,
  output logic [N_W-1:0] n0,
  output logic [N_W-1:0] n1,
  output logic [N_W-1:0] n2,
  output logic [N_W-1:0] n3
);

  localparam int unsigned W0 = pow2_mod(12);
  localparam int unsigned W1 = pow2_mod(18);
  localparam int unsigned W2 = pow2_mod(23);
  localparam int unsigned W3 = pow2_mod(28);

  term_t t0, t1, t2, t3;

  assign t0 = fold(chunk_res(z[17:12], W0));
  assign t1 = fold(chunk_res({1'b0, z[22:18]}, W1));
  assign t2 = fold(chunk_res({1'b0, z[27:23]}, W2));
  assign t3 = fold(chunk_res({1'b0, z[32:28]}, W3));

  assign p0 = {1'b0, z[11:0]};
  assign p1 = t0.pos + t1.pos + t2.pos + t3.pos;
  assign n0 = t0.neg;
  assign n1 = t1.neg;
  assign n2 = t2.neg;
  assign n3 = t3.neg;

endmodule

// File: rtl/mod4591_final_sub.sv
// Final correction: subtract the largest multiple of Q (up to 4Q)
// not exceeding s, giving a result in 0..Q-1.
module mod4591_final_sub
  import mod4591_pkg::*;
(
  input  logic [S_W-1:0] s,
  output logic [R_W-1:0] r
);

  logic [S_W-1:0] sub;

  always_comb begin
    sub = '0;
    unique case (1'b1)
      s >= S_W'(Q4):
        sub = S_W'(Q4);
      s >= S_W'(Q3) && s < S_W'(Q4):
        sub = S_W'(Q3);
      s >= S_W'(Q2) && s < S_W'(Q3):
        sub = S_W'(Q2);
      s >= S_W'(Q1) && s < S_W'(Q2):
        sub = S_W'(Q1);
      default:
        sub = '0;
    endcase
  end

  assign r = R_W'(s - sub);

endmodule

// File: rtl/mod4591_red_arb.sv
// Two-client arbiter in front of a shared 4-stage mod-4591 reducer.
// Results return in accept order, tagged with the source client.
module mod4591_red_arb
  import mod4591_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [Z_W-1:0] req0_z,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [Z_W-1:0] req1_z,
  output logic           req1_ready,
  output logic           out_valid,
  output logic [R_W-1:0] out_data,
  output logic           out_tag,
  input  logic           out_ready,
  output logic           busy
);

  s1_t s1, s1_nxt;
  s2_t s2, s2_nxt;
  s3_t s3, s3_nxt;

  logic           ptr;
  logic           stall;
  logic           en_o, en3, en2, en1;
  logic           pick1, acc;
  logic [R_W-1:0] p0, p1, fin;
  logic [N_W-1:0] n0, n1, n2, n3;

  assign stall = out_valid & ~out_ready;
  assign en_o  = ~stall;
  assign en3   = en_o | ~s3.v;
  assign en2   = en3 | ~s2.v;
  assign en1   = en2 | ~s1.v;

  // ptr=1 means client 1 is preferred when both are valid
  assign pick1 = req1_valid & (~req0_valid | (RR_EN & ptr));
  assign req0_ready = ~rst & ~stall & ~pick1;
  assign req1_ready = ~rst & ~stall & pick1;
  assign acc = (req0_valid & req0_ready)
             | (req1_valid & req1_ready);

  mod4591Svec33 u_split (
    .z  (s1.z),
    .p0 (p0),
    .p1 (p1),
    .n0 (n0),
    .n1 (n1),
    .n2 (n2),
    .n3 (n3)
  );

  mod4591_final_sub u_fin (
    .s (s3.s),
    .r (fin)
  );

  always_comb begin
    s1_nxt     = '0;
    s1_nxt.v   = acc;
    s1_nxt.tag = pick1;
    s1_nxt.z   = pick1 ? req1_z : req0_z;
  end

  always_comb begin
    s2_nxt     = '0;
    s2_nxt.v   = s1.v;
    s2_nxt.tag = s1.tag;
    s2_nxt.p0  = p0;
    s2_nxt.p1  = p1;
    s2_nxt.n0  = n0;
    s2_nxt.n1  = n1;
    s2_nxt.n2  = n2;
    s2_nxt.n3  = n3;
  end

  always_comb begin
    s3_nxt     = '0;
    s3_nxt.v   = s2.v;
    s3_nxt.tag = s2.tag;
    s3_nxt.s   = S_W'(s2.p0) + S_W'(s2.p1)
               + S_W'(OFFSET)
               - (S_W'(s2.n0) + S_W'(s2.n1)
                + S_W'(s2.n2) + S_W'(s2.n3));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= 1'b0;
      ptr       <= 1'b0;
    end else begin
      if (en1) s1 <= s1_nxt;
      if (en2) s2 <= s2_nxt;
      if (en3) s3 <= s3_nxt;
      if (en_o) begin
        out_valid <= s3.v;
        out_data  <= fin;
        out_tag   <= s3.tag;
      end
      if (acc) ptr <= ~pick1;
    end
  end

  assign busy = |{s1.v, s2.v, s3.v, out_valid};

endmodule

// File: tb/tb_mod4591_red_arb.sv
// Bench for mod4591_red_arb: vector table, handshake scoreboard,
// round-robin/priority, stall, reset-flush and random traffic.
`timescale 1ns/1ps
module tb_mod4591_red_arb;

  localparam longint unsigned QM = 4591;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [32:0] req0_z, req1_z;
  logic        out_valid, out_ready, out_tag, busy;
  logic [12:0] out_data;

  logic        fp0_valid, fp1_valid, fp0_ready, fp1_ready;
  logic [32:0] fp0_z, fp1_z;
  logic        fp_out_valid, fp_out_ready, fp_out_tag, fp_busy;
  logic [12:0] fp_out_data;

  always #5 clk = ~clk;

  mod4591_red_arb #(.RR_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_z     (req0_z),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_z     (req1_z),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  mod4591_red_arb #(.RR_EN(1'b0)) dut_fp (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (fp0_valid),
    .req0_z     (fp0_z),
    .req0_ready (fp0_ready),
    .req1_valid (fp1_valid),
    .req1_z     (fp1_z),
    .req1_ready (fp1_ready),
    .out_valid  (fp_out_valid),
    .out_data   (fp_out_data),
    .out_tag    (fp_out_tag),
    .out_ready  (fp_out_ready),
    .busy       (fp_busy)
  );

  typedef struct packed {
    logic        tag;
    logic [12:0] data;
  } exp_t;

  typedef struct {
    logic        tag;
    logic [32:0] z;
    logic [12:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          n_out = 0;
  exp_t        sb[$];
  exp_t        fsb[$];
  logic [32:0] q0[$], q1[$], f0[$], f1[$];
  int          glog[$], fgl[$];
  exp_t        mon_e;
  logic        hold_q = 1'b0;
  logic [12:0] hold_d;
  logic        hold_t;

  function automatic logic [12:0] gold(input logic [32:0] z);
    longint unsigned x;
    x = 64'(z);
    return 13'(x % QM);
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_q = 1'b0;
    end else begin
      chk("ready_onehot", req0_ready & req1_ready, 0);
      if (hold_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
        chk("hold_tag", out_tag, hold_t);
      end
      if (out_valid && !out_ready)
        chk("stall_ready", {req0_ready, req1_ready}, 0);
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra got data %0d tag %0d exp none",
                   out_data, out_tag);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_data", out_data, mon_e.data);
          chk("sb_tag", out_tag, mon_e.tag);
        end
      end
      if (req0_valid && req0_ready)
        sb.push_back({1'b0, gold(req0_z)});
      if (req1_valid && req1_ready)
        sb.push_back({1'b1, gold(req1_z)});
      hold_q = out_valid && !out_ready;
      hold_d = out_data;
      hold_t = out_tag;
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Accepting edge k puts the result out at edge k+3, which is the
  // 4th negedge counted after edge k.
  task automatic send_one(input logic tag, input logic [32:0] z,
                          output int lat, output logic [12:0] d,
                          output logic t);
    int n;
    logic ok;
    if (tag) begin req1_valid = 1'b1; req1_z = z; end
    else begin req0_valid = 1'b1; req0_z = z; end
    n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      ok = tag ? req1_ready : req0_ready;
    end
    chk("accept", ok, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    d = out_data;
    t = out_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int mode, input int budget);
    int   cyc;
    logic v0, v1;
    cyc = 0;
    v0 = 1'b0;
    v1 = 1'b0;
    glog.delete();
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0
            || busy) && cyc < budget) begin
      if (!v0 && q0.size() != 0)
        v0 = (mode != 2) || ($urandom_range(0, 1) == 1);
      if (!v1 && q1.size() != 0)
        v1 = (mode != 2) || ($urandom_range(0, 1) == 1);
      req0_valid = v0;
      req0_z = v0 ? q0[0] : '0;
      req1_valid = v1;
      req1_z = v1 ? q1[0] : '0;
      if (mode == 2) out_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 1) out_ready = !(cyc >= 6 && cyc < 11);
      else out_ready = 1'b1;
      @(negedge clk);
      if (req0_valid && req0_ready) begin
        void'(q0.pop_front());
        glog.push_back(0);
        v0 = 1'b0;
      end
      if (req1_valid && req1_ready) begin
        void'(q1.pop_front());
        glog.push_back(1);
        v1 = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b1;
    chk("drain", int'(cyc < budget), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[11];
    int          lat, cyc, base;
    logic [12:0] d;
    logic        t;
    logic [32:0] z;

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_z = '0; req1_z = '0;
    out_ready = 1'b1;
    fp0_valid = 1'b0; fp1_valid = 1'b0;
    fp0_z = '0; fp1_z = '0;
    fp_out_ready = 1'b1;

    vt[0]  = '{1'b0, 33'd0, 13'd0};
    vt[1]  = '{1'b1, 33'd12345678, 13'd479};
    vt[2]  = '{1'b0, 33'd4590, 13'd4590};
    vt[3]  = '{1'b0, 33'd4591, 13'd0};
    vt[4]  = '{1'b0, 33'h1_FFFF_FFFF, 13'd3724};
    vt[5]  = '{1'b1, 33'd9181, 13'd4590};
    vt[6]  = '{1'b1, 33'd9182, 13'd0};
    vt[7]  = '{1'b0, 33'd22955, 13'd0};
    vt[8]  = '{1'b1, 33'd4592, 13'd1};
    vt[9]  = '{1'b0, 33'd18363, 13'd4590};
    vt[10] = '{1'b1, 33'h1_0000_0000, 13'd4158};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      send_one(vt[i].tag, vt[i].z, lat, d, t);
      chk("vec_latency", lat, 4);
      chk("vec_data", d, vt[i].exp);
      chk("vec_tag", t, vt[i].tag);
    end
    @(negedge clk);
    chk("idle_busy", busy, 0);
    @(posedge clk);
    #1;

    // Round robin with both clients always valid.
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(33'(1000 + i * 4591 * 7 + i));
      q1.push_back(33'(64'h1_2345_0000 + i * 12345));
    end
    run_stream(0, 200);
    chk("rr_len", glog.size(), 12);
    for (int i = 0; i < glog.size(); i++)
      chk("rr_grant", glog[i], i % 2);

    // Stall window of five cycles mid-stream.
    base = n_out;
    for (int i = 0; i < 6; i++) begin
      q0.push_back(33'(i * 987654 + 3));
      q1.push_back(33'(64'h1_FFFF_FFFF - i * 5555));
    end
    run_stream(1, 200);
    chk("stall_count", n_out - base, 12);

    // Fixed priority instance: client 0 drains first.
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      f0.push_back(33'(i * 77777 + 11));
      f1.push_back(33'(i * 4591 + 4590));
    end
    cyc = 0;
    fgl.delete();
    while ((f0.size() != 0 || f1.size() != 0 || fsb.size() != 0)
           && cyc < 200) begin
      fp0_valid = (f0.size() != 0);
      fp0_z = fp0_valid ? f0[0] : '0;
      fp1_valid = (f1.size() != 0);
      fp1_z = fp1_valid ? f1[0] : '0;
      @(negedge clk);
      if (fp_out_valid) begin
        if (fsb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fp_extra got data %0d exp none", fp_out_data);
        end else begin
          mon_e = fsb.pop_front();
          chk("fp_data", fp_out_data, mon_e.data);
          chk("fp_tag", fp_out_tag, mon_e.tag);
        end
      end
      if (fp0_valid && fp0_ready) begin
        fsb.push_back({1'b0, gold(f0[0])});
        void'(f0.pop_front());
        fgl.push_back(0);
      end
      if (fp1_valid && fp1_ready) begin
        fsb.push_back({1'b1, gold(f1[0])});
        void'(f1.pop_front());
        fgl.push_back(1);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    fp0_valid = 1'b0;
    fp1_valid = 1'b0;
    chk("fp_drain", int'(cyc < 200), 1);
    chk("fp_len", fgl.size(), 12);
    for (int i = 0; i < fgl.size(); i++)
      chk("fp_grant", fgl[i], (i < 6) ? 0 : 1);
    @(negedge clk);
    chk("fp_idle", fp_busy, 0);
    @(posedge clk);
    #1;

    // Reset with three operands in flight.
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_z = 33'(5000 + i);
      @(negedge clk);
      chk("flush_accept", req0_ready, 1);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("flush_quiet", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send_one(1'b1, 33'd12345678, lat, d, t);
    chk("post_rst_data", d, 479);
    chk("post_rst_tag", t, 1);
    chk("post_rst_lat", lat, 4);

    // Random traffic on both clients with random backpressure.
    base = n_out;
    for (int i = 0; i < 1000; i++) begin
      z = {$urandom_range(0, 1) == 1, $urandom()};
      if ($urandom_range(0, 7) == 0) z = 33'($urandom_range(0, 30000));
      q0.push_back(z);
      z = {$urandom_range(0, 1) == 1, $urandom()};
      if ($urandom_range(0, 7) == 0) z = 33'($urandom_range(0, 30000));
      q1.push_back(z);
    end
    run_stream(2, 20000);
    chk("rand_count", n_out - base, 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
